// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, RGB444 colours and bank-swap FSM states
// for the VGA output path (also used by the h/v counter block).
package vga_pkg;

    localparam int WIDTH   = 640;
    localparam int HEIGHT  = 480;
    localparam int H_TOTAL = 800;
    localparam int V_TOTAL = 525;

    localparam logic [9:0] H_SYNC_START = 10'd16;
    localparam logic [9:0] H_SYNC_END   = 10'd112;
    localparam logic [9:0] H_DISP_START = 10'd160;
    localparam logic [9:0] V_SYNC_START = 10'd10;
    localparam logic [9:0] V_SYNC_END   = 10'd12;
    localparam logic [9:0] V_DISP_START = 10'd45;

    localparam logic [11:0] RGB_WHITE = 12'hFFF;
    localparam logic [11:0] RGB_BLACK = 12'h000;
    localparam logic [11:0] RGB_GREY  = 12'h333;

    typedef enum logic [1:0] {
        SWAP_LOCK = 2'd0,
        SWAP_OPEN = 2'd1,
        SWAP_DONE = 2'd2
    } swap_state_t;

endpackage

// File: rtl/vga_bank_swap_ctrl.sv
// Displayed-bank ownership: the life engine may flip the bank at most once per
// vertical blanking interval, never while visible lines are being fetched.
module vga_bank_swap_ctrl
    import vga_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic vblank_i,
    input  logic swap_req_i,
    output logic swap_ack_o,
    output logic rd_bank_o
);

    // Handshake: swap_req_i is a level held by the engine until it sees the
    // one-cycle swap_ack_o pulse; rd_bank_o changes on the same edge as the ack.
    swap_state_t state_q, state_d;
    logic        bank_q, bank_d;
    logic        ack_q, ack_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= SWAP_LOCK;
            bank_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        ack_d   = 1'b0;
        unique case (state_q)
            SWAP_LOCK: begin
                if (vblank_i) state_d = SWAP_OPEN;
            end
            SWAP_OPEN: begin
                if (!vblank_i) begin
                    state_d = SWAP_LOCK;
                end else if (swap_req_i) begin
                    bank_d  = ~bank_q;
                    ack_d   = 1'b1;
                    state_d = SWAP_DONE;
                end
            end
            SWAP_DONE: begin
                if (!vblank_i) state_d = SWAP_LOCK;
            end
            default: state_d = SWAP_LOCK;
        endcase
    end

    assign swap_ack_o = ack_q;
    assign rd_bank_o  = bank_q;

endmodule

// File: rtl/vga_cell_renderer.sv
// Turns raw h/v counts into 2-cycle pipelined sync/de/RGB, drawing each life-grid
// cell as a square block fetched from the displayed RAM bank.
module vga_cell_renderer
    import vga_pkg::*;
#(
    parameter int          CELL_SHIFT = 3,
    parameter int          GRID_W     = 80,
    parameter int          GRID_H     = 60,
    parameter bit          GRID_EN    = 1'b1,
    parameter logic [11:0] COL_ALIVE  = RGB_WHITE,
    parameter logic [11:0] COL_DEAD   = RGB_BLACK,
    parameter logic [11:0] COL_GRID   = RGB_GREY
) (
    input  logic        plk,
    input  logic        rst,
    input  logic [9:0]  h_count,
    input  logic [9:0]  v_count,
    output logic        rd_en,
    output logic [12:0] rd_addr,
    output logic        rd_bank,
    input  logic        cell_q,
    input  logic        swap_req,
    output logic        swap_ack,
    output logic        frame_start,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        de,
    output logic [11:0] rgb
);

    localparam int         CX_W      = $clog2(GRID_W);
    localparam int         CY_W      = $clog2(GRID_H);
    localparam logic [9:0] CELL_MASK = 10'((1 << CELL_SHIFT) - 1);

    // Stage 0: decode straight off the counter outputs.
    logic            hs0, vs0, disp0, grid0;
    logic [9:0]      x0, y0;
    logic [CX_W-1:0] cell_x0;
    logic [CY_W-1:0] cell_y0;
    logic [12:0]     addr0;

    assign hs0     = (h_count >= H_SYNC_START) && (h_count < H_SYNC_END);
    assign vs0     = (v_count >= V_SYNC_START) && (v_count < V_SYNC_END);
    assign disp0   = (h_count >= H_DISP_START) && (v_count >= V_DISP_START);
    assign x0      = h_count - H_DISP_START;
    assign y0      = v_count - V_DISP_START;
    assign cell_x0 = CX_W'(x0 >> CELL_SHIFT);
    assign cell_y0 = CY_W'(y0 >> CELL_SHIFT);
    assign grid0   = ((x0 & CELL_MASK) == 10'd0) || ((y0 & CELL_MASK) == 10'd0);

    // 80 = 64 + 16, so the row offset needs only two shifts and an add.
    generate
        if (GRID_W == 80) begin : g_addr_shift
            assign addr0 = (13'(cell_y0) << 6) + (13'(cell_y0) << 4) + 13'(cell_x0);
        end else begin : g_addr_mul
            assign addr0 = 13'(cell_y0) * 13'(GRID_W) + 13'(cell_x0);
        end
    endgenerate

    // Stage 1: RAM request plus delayed timing flags.
    logic        rd_en_q, hs1_q, vs1_q, disp1_q, grid1_q;
    logic [12:0] rd_addr_q, rd_addr_d;
    logic        frame_start_q;

    assign rd_addr_d = disp0 ? addr0 : rd_addr_q;

    always_ff @(posedge plk) begin
        if (rst) begin
            rd_en_q       <= 1'b0;
            rd_addr_q     <= 13'd0;
            hs1_q         <= 1'b0;
            vs1_q         <= 1'b0;
            disp1_q       <= 1'b0;
            grid1_q       <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            rd_en_q       <= disp0;
            rd_addr_q     <= rd_addr_d;
            hs1_q         <= hs0;
            vs1_q         <= vs0;
            disp1_q       <= disp0;
            grid1_q       <= grid0;
            frame_start_q <= (h_count == 10'd0) && (v_count == 10'd0);
        end
    end

    // Stage 2: cell data lands here, aligned with the delayed sync flags.
    logic        hsync_n_q, vsync_n_q, de_q;
    logic [11:0] rgb_q, rgb_d;

    always_comb begin
        rgb_d = 12'h000;
        if (disp1_q) begin
            if (cell_q)                  rgb_d = COL_ALIVE;
            else if (GRID_EN && grid1_q) rgb_d = COL_GRID;
            else                         rgb_d = COL_DEAD;
        end
    end

    always_ff @(posedge plk) begin
        if (rst) begin
            hsync_n_q <= 1'b1;
            vsync_n_q <= 1'b1;
            de_q      <= 1'b0;
            rgb_q     <= 12'h000;
        end else begin
            hsync_n_q <= ~hs1_q;
            vsync_n_q <= ~vs1_q;
            de_q      <= disp1_q;
            rgb_q     <= rgb_d;
        end
    end

    vga_bank_swap_ctrl u_swap (
        .clk_i      (plk),
        .rst_i      (rst),
        .vblank_i   (v_count < V_DISP_START),
        .swap_req_i (swap_req),
        .swap_ack_o (swap_ack),
        .rd_bank_o  (rd_bank)
    );

    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_addr_q;
    assign frame_start = frame_start_q;
    assign hsync_n     = hsync_n_q;
    assign vsync_n     = vsync_n_q;
    assign de          = de_q;
    assign rgb         = rgb_q;

endmodule

// File: tb/tb_vga_cell_renderer.sv
// Scoreboard bench for vga_cell_renderer: a per-cycle reference model pushes
// expected outputs tagged with their due cycle; a monitor pops and compares.
module tb_vga_cell_renderer;

    logic        plk = 1'b0;
    logic        rst;
    logic [9:0]  h_count, v_count;
    logic        rd_en;
    logic [12:0] rd_addr;
    logic        rd_bank;
    logic        cell_q;
    logic        swap_req;
    logic        swap_ack;
    logic        frame_start;
    logic        hsync_n, vsync_n, de;
    logic [11:0] rgb;

    // clock / reset
    always #20 plk = ~plk;

    vga_cell_renderer dut (
        .plk         (plk),
        .rst         (rst),
        .h_count     (h_count),
        .v_count     (v_count),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_bank     (rd_bank),
        .cell_q      (cell_q),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .frame_start (frame_start),
        .hsync_n     (hsync_n),
        .vsync_n     (vsync_n),
        .de          (de),
        .rgb         (rgb)
    );

    int cyc = 0;
    always @(posedge plk) cyc <= cyc + 1;

    // life-grid RAM contents, two banks
    logic mem [0:1][0:4799];

    // scoreboard queues: {due_cycle[31:0], payload[15:0]}
    logic [47:0] vid_q[$];
    logic [47:0] rd_q[$];
    logic [47:0] ctl_q[$];

    int errors = 0;
    int checks = 0;

    // reference model state
    logic prev_rst  = 1'b1;
    logic prev_hs   = 1'b0;
    logic prev_vs   = 1'b0;
    logic prev_disp = 1'b0;
    logic prev_grid = 1'b0;
    logic prev_cell = 1'b0;
    int   addr_hold = 0;
    int   vb_run    = 0;
    logic swapped   = 1'b0;
    logic bank_m    = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [11:0] colour_of(input logic disp, input logic alive, input logic on_grid);
        if (!disp)   return 12'h000;
        if (alive)   return 12'hFFF;
        if (on_grid) return 12'h333;
        return 12'h000;
    endfunction

    // driver: one call = one set of inputs sampled at the next rising edge
    task automatic step(input int h, input int v, input logic req, input logic r);
        int          due, addr;
        logic        hs, vs, disp, grid, vb, ack, fs;
        logic [14:0] vid;
        @(negedge plk);
        cell_q   = rd_en ? mem[rd_bank][rd_addr] : 1'($urandom_range(0, 1));
        h_count  = 10'(h);
        v_count  = 10'(v);
        swap_req = req;
        rst      = r;
        due      = cyc + 1;

        hs   = (h >= 16) && (h < 112);
        vs   = (v >= 10) && (v < 12);
        disp = (h >= 160) && (v >= 45);
        grid = ((h - 160) % 8 == 0) || ((v - 45) % 8 == 0);
        addr = ((v - 45) / 8) * 80 + (h - 160) / 8;

        if (r || prev_rst) vid = {1'b1, 1'b1, 1'b0, 12'h000};
        else vid = {~prev_hs, ~prev_vs, prev_disp, colour_of(prev_disp, prev_cell, prev_grid)};

        if (r) addr_hold = 0;
        else if (disp) addr_hold = addr;

        vb = (v < 45);
        if (r) begin
            vb_run = 0; swapped = 1'b0; bank_m = 1'b0; ack = 1'b0;
        end else begin
            ack = vb && (vb_run >= 1) && !swapped && req;
            if (ack) begin
                bank_m  = ~bank_m;
                swapped = 1'b1;
            end
            if (vb) vb_run++;
            else begin
                vb_run  = 0;
                swapped = 1'b0;
            end
        end
        fs = !r && (h == 0) && (v == 0);

        vid_q.push_back({32'(due), 1'b0, vid});
        rd_q.push_back({32'(due), 2'b00, (!r && disp), 13'(addr_hold)});
        ctl_q.push_back({32'(due), 13'd0, ack, bank_m, fs});

        prev_rst  = r;
        prev_hs   = hs;
        prev_vs   = vs;
        prev_disp = disp;
        prev_grid = grid;
        prev_cell = mem[bank_m][addr_hold];
    endtask

    // monitor: compare whatever is due this cycle
    logic [47:0] e;
    always @(posedge plk) begin
        #1;
        if (vid_q.size() > 0 && int'(vid_q[0][47:16]) == cyc) begin
            e = vid_q.pop_front();
            check("hsync_n", 16'(hsync_n), 16'(e[14]));
            check("vsync_n", 16'(vsync_n), 16'(e[13]));
            check("de",      16'(de),      16'(e[12]));
            check("rgb",     16'(rgb),     16'(e[11:0]));
        end
        if (rd_q.size() > 0 && int'(rd_q[0][47:16]) == cyc) begin
            e = rd_q.pop_front();
            check("rd_en",   16'(rd_en),   16'(e[13]));
            check("rd_addr", 16'(rd_addr), 16'(e[12:0]));
        end
        if (ctl_q.size() > 0 && int'(ctl_q[0][47:16]) == cyc) begin
            e = ctl_q.pop_front();
            check("swap_ack",    16'(swap_ack),    16'(e[2]));
            check("rd_bank",     16'(rd_bank),     16'(e[1]));
            check("frame_start", 16'(frame_start), 16'(e[0]));
        end
    end

    initial begin
        int   h, v, len;
        logic vbm, req;
        rst      = 1'b1;
        h_count  = 10'd0;
        v_count  = 10'd0;
        swap_req = 1'b0;
        cell_q   = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int a = 0; a < 4800; a++)
                mem[b][a] = 1'($urandom_range(0, 1));
        mem[0][0] = 1'b1;
        mem[0][1] = 1'b0;

        // reset and timing decode boundaries
        repeat (3) step(0, 0, 1'b0, 1'b1);
        step(0, 0, 1'b0, 1'b0);
        step(16, 0, 1'b0, 1'b0);
        step(111, 0, 1'b0, 1'b0);
        step(112, 0, 1'b0, 1'b0);
        step(300, 10, 1'b0, 1'b0);
        step(300, 11, 1'b0, 1'b0);
        step(300, 12, 1'b0, 1'b0);
        step(159, 45, 1'b0, 1'b0);
        step(160, 45, 1'b0, 1'b0);
        step(160, 44, 1'b0, 1'b0);
        step(799, 524, 1'b0, 1'b0);
        step(168, 50, 1'b0, 1'b0);
        step(171, 51, 1'b0, 1'b0);
        step(0, 300, 1'b0, 1'b0);
        for (int x = 150; x < 200; x++) step(x, 53, 1'b0, 1'b0);

        // request raised in the visible area, held across two frames
        for (int y = 100; y < 525; y++) step($urandom_range(0, 799), y, 1'b1, 1'b0);
        for (int y = 0; y < 61; y++)    step($urandom_range(0, 799), y, 1'b1, 1'b0);
        for (int y = 61; y < 525; y++)  step($urandom_range(0, 799), y, 1'b1, 1'b0);
        for (int y = 0; y < 45; y++)    step($urandom_range(0, 799), y, 1'b1, 1'b0);
        step(400, 45, 1'b0, 1'b0);

        // reset while a request is pending at the start of vblank
        step(300, 524, 1'b1, 1'b0);
        step(0, 0, 1'b1, 1'b1);
        for (int y = 1; y < 45; y++) step(200, y, 1'b1, 1'b0);
        step(200, 45, 1'b0, 1'b0);

        // randomized bursts of blanking / visible counts
        for (int s = 0; s < 300; s++) begin
            vbm = ($urandom_range(0, 2) == 0);
            len = $urandom_range(1, 14);
            req = 1'($urandom_range(0, 1));
            for (int k = 0; k < len; k++) begin
                h = $urandom_range(0, 799);
                v = vbm ? $urandom_range(0, 44) : $urandom_range(45, 524);
                if ($urandom_range(0, 15) == 0) begin
                    h = 0;
                    v = 0;
                end
                step(h, v, req ^ ($urandom_range(0, 7) == 0), ($urandom_range(0, 59) == 0));
            end
        end

        repeat (3) step(300, 300, 1'b0, 1'b0);
        @(posedge plk);
        #2;
        check("drain", 16'(vid_q.size() + rd_q.size() + ctl_q.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
